// File: rtl/rx_frame_decoder_if.sv
// rx_frame_decoder_if: byte input, message output and error-pulse bundle of the frame decoder.
// The master drives the received bytes and the ack; the slave is the decoder.
interface rx_frame_decoder_if #(
    parameter int MAX_BYTES = 10
);
    logic [7:0] byte_in;
    logic byte_valid;
    logic msg_ack;
    logic msg_valid;
    logic [7:0] msg_head;
    logic [7:0] msg_len;
    logic [8*MAX_BYTES-1:0] msg_data;
    logic busy;
    logic err_frame;
    logic err_overflow;
    logic err_timeout;
    logic err_overrun;
    modport master (
        output byte_in, byte_valid, msg_ack,
        input msg_valid, msg_head, msg_len, msg_data, busy,
        input err_frame, err_overflow, err_timeout, err_overrun
    );
    modport slave (
        input byte_in, byte_valid, msg_ack,
        output msg_valid, msg_head, msg_len, msg_data, busy,
        output err_frame, err_overflow, err_timeout, err_overrun
    );
endinterface

// File: rtl/rx_frame_decoder.sv
// rx_frame_decoder: SYNC/ESC framed UART message decoder with held-valid/ack output register.
// Defining RX_FRAME_CHECKSUM_EN adds a mod-256 checksum byte between the payload and END.
module rx_frame_decoder #(
    parameter int MAX_BYTES = 10,
    parameter int TIMEOUT = 100,
    parameter int TOUT_W = 16,
    parameter logic [7:0] SP_SYNC = 8'h7E,
    parameter logic [7:0] SP_ESC = 8'hFE,
    parameter logic [7:0] SP_END = 8'h03
) (
    input logic ct_rxclk,
    input logic reset,
    rx_frame_decoder_if.slave bus
);
    localparam logic [7:0] MAX_N = 8'(MAX_BYTES);
    localparam logic [TOUT_W-1:0] TOUT_LIM = TOUT_W'(TIMEOUT);
`ifdef RX_FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, BCNT, BODY, CHK, TAIL} stateT;
    localparam stateT POST_BODY = CHK;
`else
    typedef enum logic [1:0] {IDLE, BCNT, BODY, TAIL} stateT;
    localparam stateT POST_BODY = TAIL;
`endif
    stateT state, stateNext;
    logic escFlag, escNext;
    logic [TOUT_W-1:0] toutCnt, toutNext;
    logic [7:0] rxCnt, rxNext;
    logic [7:0] nLen, nNext;
    logic [7:0] head, headNext;
    logic [8*MAX_BYTES-1:0] workBuf, bufNext;
    logic publish, errFrameNext, errOverflowNext, errTimeoutNext;
    logic isEsc, isSync, isEnd, expire;
    assign isEsc = !escFlag && bus.byte_in == SP_ESC;
    assign isSync = !escFlag && bus.byte_in == SP_SYNC;
    assign isEnd = !escFlag && bus.byte_in == SP_END;
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign expire = state != IDLE && !bus.byte_valid && toutCnt == TOUT_LIM;
    assign bus.busy = state != IDLE || escFlag;
`ifdef RX_FRAME_CHECKSUM_EN
    logic [7:0] sum;
    logic sumOk;
    assign sumOk = 8'(sum + bus.byte_in) == 8'd0;
    always_ff @(posedge ct_rxclk or negedge reset) begin
        if (!reset)
            sum <= '0;
        else if (bus.byte_valid && !isEsc)
            sum <= isSync ? 8'd0 : (state == BCNT || state == BODY) ? sum + bus.byte_in : sum;
    end
`endif
    always_comb begin
        stateNext = state;
        escNext = escFlag;
        toutNext = (bus.byte_valid || state == IDLE) ? '0 : toutCnt + 1'b1;
        rxNext = rxCnt;
        nNext = nLen;
        headNext = head;
        bufNext = workBuf;
        publish = 1'b0;
        errFrameNext = 1'b0;
        errOverflowNext = 1'b0;
        errTimeoutNext = 1'b0;
        if (expire) begin
            stateNext = IDLE;
            escNext = 1'b0;
            toutNext = '0;
            errTimeoutNext = 1'b1;
        end else if (bus.byte_valid && isEsc) begin
            escNext = state != IDLE;
        end else if (bus.byte_valid && isSync) begin
            stateNext = BCNT;
            headNext = bus.byte_in;
            bufNext = '0;
            rxNext = '0;
        end else if (bus.byte_valid) begin
            escNext = 1'b0;
            case (state)
                BCNT: begin
                    nNext = bus.byte_in;
                    rxNext = '0;
                    errOverflowNext = bus.byte_in > MAX_N;
                    stateNext = bus.byte_in > MAX_N ? IDLE : bus.byte_in == 8'd0 ? POST_BODY : BODY;
                end
                BODY: begin
                    bufNext[8*rxCnt +: 8] = bus.byte_in;
                    rxNext = rxCnt + 8'd1;
                    stateNext = rxNext == nLen ? POST_BODY : BODY;
                end
`ifdef RX_FRAME_CHECKSUM_EN
                CHK: begin
                    errFrameNext = !sumOk;
                    stateNext = sumOk ? TAIL : IDLE;
                end
`endif
                TAIL: begin
                    publish = isEnd;
                    errFrameNext = !isEnd;
                    stateNext = IDLE;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge ct_rxclk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            escFlag <= 1'b0;
            toutCnt <= '0;
            rxCnt <= '0;
            nLen <= '0;
            head <= '0;
            workBuf <= '0;
            bus.msg_valid <= 1'b0;
            bus.msg_head <= '0;
            bus.msg_len <= '0;
            bus.msg_data <= '0;
            bus.err_frame <= 1'b0;
            bus.err_overflow <= 1'b0;
            bus.err_timeout <= 1'b0;
            bus.err_overrun <= 1'b0;
        end else begin
            state <= stateNext;
            escFlag <= escNext;
            toutCnt <= toutNext;
            rxCnt <= rxNext;
            nLen <= nNext;
            head <= headNext;
            workBuf <= bufNext;
            bus.err_frame <= errFrameNext;
            bus.err_overflow <= errOverflowNext;
            bus.err_timeout <= errTimeoutNext;
            bus.err_overrun <= publish && bus.msg_valid && !bus.msg_ack;
            if (publish) begin
                bus.msg_valid <= 1'b1;
                bus.msg_head <= head;
                bus.msg_len <= nLen;
                bus.msg_data <= workBuf;
            end else if (bus.msg_ack) begin
                bus.msg_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/rx_frame_decoder.md
Name: rx_frame_decoder

Overview:
- Parametrised framed-message decoder for the UART receive path.
- Accepts one unloaded byte per `byte_valid` strobe and strips SYNC/ESC framing.
- Collects a byte-counted payload into a working buffer, checks the END byte, enforces an inter-byte timeout, then publishes the completed frame through a held-valid/ack output register to downstream message handlers (dot-matrix, LED display).

Parameters:
- MAX_BYTES, 10, payload buffer depth in bytes (1..255).
- TIMEOUT, 100, max `ct_rxclk` cycles between bytes inside a frame before abort.
- TOUT_W, 16, timeout counter width; must hold TIMEOUT+1.
- SP_SYNC, 8'h7E, frame start byte.
- SP_ESC, 8'hFE, escape byte; the next byte is taken literally.
- SP_END, 8'h03, frame terminator.

Ports:
- ct_rxclk  in  1  logic clock.
- reset  in  1  asynchronous, active-low.
- byte_in  in  8  received byte, sampled when byte_valid=1.
- byte_valid  in  1  one-cycle strobe, one byte per strobe.
- msg_ack  in  1  consumer has taken the published message.
- msg_valid  out  1  published message available; held until ack.
- msg_head  out  8  SYNC byte that opened the frame.
- msg_len  out  8  payload byte count of the published message.
- msg_data  out  8*MAX_BYTES  payload; byte 0 in bits [7:0]; unused bytes zero.
- busy  out  1  decoder is inside a frame (state != IDLE).
- err_frame  out  1  one-cycle pulse: bad END byte.
- err_overflow  out  1  one-cycle pulse: count > MAX_BYTES.
- err_timeout  out  1  one-cycle pulse: inter-byte timeout.
- err_overrun  out  1  one-cycle pulse: published message overwritten before ack.

Behaviour:
- Reset (async, active-low): state=IDLE, esc flag=0, counters=0, working buffer=0. All outputs 0, including msg_data, msg_len, msg_head, msg_valid and every err_*.
- States: IDLE, BCNT, BODY, TAIL. Transitions occur only on cycles with byte_valid=1, except timeout.
- ESC handling:
  - An unescaped SP_ESC sets the esc flag and is discarded; state is unchanged.
  - The next byte clears the flag and is treated as data in the current state, never as SYNC/ESC/END.
  - ESC in IDLE is discarded.
- SYNC handling: an unescaped SP_SYNC in any state latches head, clears the working buffer and rx count, and goes to BCNT. A partial frame is dropped silently with no error.
- IDLE: non-SYNC bytes are ignored.
- BCNT: the byte becomes N.
  - N > MAX_BYTES -> err_overflow pulse, go to IDLE.
  - N == 0 -> TAIL.
  - Otherwise -> BODY.
- BODY: store the byte at index rx count, then increment the count. When count reaches N, go to TAIL.
- TAIL:
  - byte == SP_END (unescaped) -> publish, go to IDLE.
  - Otherwise -> err_frame pulse, go to IDLE.
- Publish:
  - Copy the working buffer, N and head to the output registers. msg_valid=1 on the cycle after the END byte strobe (latency 1).
  - msg_valid stays high until a cycle with msg_ack=1, then it is 0 on the next cycle.
- Overrun:
  - Publish while msg_valid=1 and msg_ack=0 -> outputs overwritten, msg_valid stays 1, err_overrun pulses.
  - Publish and msg_ack in the same cycle -> new message valid, no overrun.
- Timeout:
  - The counter clears on every byte_valid and in IDLE, and increments each cycle otherwise.
  - When it exceeds TIMEOUT: err_timeout pulse, state=IDLE, esc flag cleared.
  - byte_valid in the same cycle as expiry wins: the byte is processed and the counter cleared.
- Error pulses are exactly one cycle wide. The output register is unaffected by any error.
- busy = (state != IDLE) || esc flag.

Optional Feature:
- Macro: RX_FRAME_CHECKSUM_EN.
- Defined:
  - Add state CHK between BODY/BCNT(N=0) and TAIL.
  - The CHK byte must make (N + sum of payload + chk) mod 256 == 0. A mismatch gives an err_frame pulse and IDLE; TAIL is not entered.
  - The checksum byte obeys ESC rules.
  - The running sum is reset on SYNC.
- Undefined: no CHK state and no sum logic; TAIL follows BODY directly.

Test Plan:
- Sequence 7E,03,11,22,33,03 -> msg_valid=1 one cycle after the last strobe; msg_len=3; msg_data[23:0]=33_22_11; msg_head=7E; no errors.
- Sequence 7E,02,FE,7E,FE,03,03 -> msg_len=2; data bytes 7E,03; no errors; busy=0 afterwards.
- Sequence 7E,0B (MAX_BYTES=10) -> err_overflow pulse; IDLE; msg_valid stays 0. Sequence 7E,01,AA,55 -> err_frame pulse; no publish.
- Sequence 7E,02,AA, then idle for 101 cycles -> err_timeout pulse on cycle 101; busy=0. A following full frame decodes correctly.
- Two valid frames back-to-back with msg_ack held 0 -> second frame's data visible; err_overrun pulse; msg_valid=1. Ack on the publish cycle -> no overrun.
- Assert reset mid-BODY -> all outputs 0 immediately. After release, 7E,00,03 -> msg_valid=1, msg_len=0. With RX_FRAME_CHECKSUM_EN defined, 7E,00,00,03 passes.
